// File: rtl/ram_scan_arbiter_if.sv
// CPU load/store bus into the RAM arbiter.
//   master : CPU side, drives request/rw/byte-enables/address/write data,
//            receives grant and read data.
//   slave  : arbiter side, the reverse.
// cpu_req is held by the CPU until cpu_gnt; cpu_rdata is valid in the
// cycle where cpu_gnt & ~cpu_rw.
interface ram_scan_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_rw;
  logic [3:0]        cpu_sel;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_rw, cpu_sel, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_rw, cpu_sel, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata
  );
endinterface

// File: rtl/ram_scan_arbiter.sv
// ram_scan_arbiter
// Shares the single data-RAM port between the CPU load/store path and a
// display scan engine. The scan engine walks a window of RAM words, holds
// each word on disp_* for HOLD_CYCLES cycles, then reads the next one.
// The CPU has priority; a starvation counter forces one scan read once the
// scan side has been denied MAX_WAIT consecutive cycles while pending.
//
// Ports
//   clk, rst       clock (rising edge) and asynchronous active-low reset
//   cpu            CPU bus (slave modport): req/rw/sel/addr/wdata in,
//                  gnt/rdata out (both combinational)
//   scan_en        enable scanning; low returns the engine to IDLE
//   scan_base      first word of the scan window
//   scan_len       words in the window (0 behaves as 1)
//   ram_rw/sel/addr/data_in   RAM port controls
//   ram_data_out   combinational RAM read data for ram_addr
//   disp_addr/data/valid      registered word presented to the LED driver
module ram_scan_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_WAIT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  ram_scan_arbiter_if.slave cpu,
  input  logic              scan_en,
  input  logic [ADDR_W-1:0] scan_base,
  input  logic [ADDR_W-1:0] scan_len,
  output logic              ram_rw,
  output logic [3:0]        ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int DWELL_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    DWELL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [ADDR_W-1:0]   disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                disp_valid_q, disp_valid_d;

  logic                pend;
  logic                force_scan;
  logic                cpu_gnt;
  logic                scan_gnt;
  logic [ADDR_W-1:0]   ptr_off;
  logic [ADDR_W-1:0]   len_m1;
  logic [ADDR_W-1:0]   ptr_next;

  // A pending scan read only exists while scan_en is high; dropping scan_en
  // withdraws the request in the same cycle, so the CPU sees no stall.
  always_comb begin
    pend       = scan_en && (state_q == PEND);
    force_scan = pend && (wait_cnt_q == WAIT_W'(MAX_WAIT));
    cpu_gnt    = cpu.cpu_req && !force_scan;
    scan_gnt   = pend && !cpu_gnt;
  end

  assign cpu.cpu_gnt   = cpu_gnt;
  assign cpu.cpu_rdata = ram_data_out;

  // RAM port mux. Writes only ever issue on a CPU grant.
  always_comb begin
    ram_rw      = 1'b0;
    ram_sel     = 4'b0000;
    ram_addr    = cpu.cpu_addr;
    ram_data_in = cpu.cpu_wdata;
    if (cpu_gnt) begin
      ram_rw  = cpu.cpu_rw;
      ram_sel = cpu.cpu_sel;
    end else if (scan_gnt) begin
      ram_sel  = 4'b1111;
      ram_addr = ptr_q;
    end
  end

  // Window advance: offset from base is taken modulo 2^ADDR_W so windows
  // that straddle the top of the address space wrap naturally. Uses the
  // current base/len, so window changes apply at the next advance.
  always_comb begin
    ptr_off = ptr_q - scan_base;
    len_m1  = (scan_len == '0) ? '0 : (scan_len - 1'b1);
    if (ptr_off >= len_m1) ptr_next = scan_base;
    else                   ptr_next = ptr_q + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    wait_cnt_d   = '0;
    dwell_cnt_d  = dwell_cnt_q;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    if (!scan_en) begin
      state_d      = IDLE;
      disp_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = PEND;
          ptr_d   = scan_base;
        end
        PEND: begin
          if (scan_gnt) begin
            disp_data_d  = ram_data_out;
            disp_addr_d  = ptr_q;
            disp_valid_d = 1'b1;
            dwell_cnt_d  = DWELL_W'(HOLD_CYCLES - 1);
            state_d      = DWELL;
          end else if (cpu_gnt) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        DWELL: begin
          if (dwell_cnt_q == '0) begin
            ptr_d   = ptr_next;
            state_d = PEND;
          end else begin
            dwell_cnt_d = dwell_cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      wait_cnt_q   <= '0;
      dwell_cnt_q  <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wait_cnt_q   <= wait_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_ram_scan_arbiter.sv
module tb_ram_scan_arbiter;
  localparam int AW = 10, DW = 32, HOLD = 4, MW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_scan_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          scan_en;
  logic [AW-1:0] scan_base, scan_len;
  logic          ram_rw;
  logic [3:0]    ram_sel;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in, ram_data_out;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;

  logic [DW-1:0] mem [1024];
  assign ram_data_out = mem[ram_addr];

  ram_scan_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOLD_CYCLES(HOLD), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .cpu(bus.slave),
    .scan_en(scan_en), .scan_base(scan_base), .scan_len(scan_len),
    .ram_rw(ram_rw), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid)
  );

  int n_chk = 0, n_fail = 0;

  // Reference model: which read of the window comes next, whether a scan
  // read is outstanding, how long it has been refused, dwell remaining.
  bit          m_on, m_pend;
  int          m_hold, m_den, m_k;
  logic          exp_dv;
  logic [AW-1:0] exp_da;
  logic [DW-1:0] exp_dd;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_pend = 0; m_hold = 0; m_den = 0; m_k = 0;
    exp_dv = 0; exp_da = '0; exp_dd = '0;
  endtask

  // One clock: called at a falling edge with inputs already driven.
  task automatic cyc();
    logic eg, sr, wr;
    logic [AW-1:0] sa, wa;
    logic [3:0] ws;
    logic [DW-1:0] wd;
    int L;
    #1;
    L  = (scan_len == 0) ? 1 : int'(scan_len);
    sa = AW'((int'(scan_base) + (m_k % L)) % 1024);
    eg = bus.cpu_req;
    sr = 1'b0;
    if (scan_en && m_on && m_pend) begin
      if (m_den == MW) eg = 1'b0;
      sr = !eg;
    end
    chk("cpu_gnt", bus.cpu_gnt, eg);
    chk("ram_rw", ram_rw, eg & bus.cpu_rw);
    if (sr) begin
      chk("scan_addr", ram_addr, sa);
      chk("scan_sel", ram_sel, 4'hf);
    end else if (eg) begin
      chk("cpu_addr", ram_addr, bus.cpu_addr);
      chk("cpu_sel", ram_sel, bus.cpu_sel);
      if (!bus.cpu_rw) chk("cpu_rdata", bus.cpu_rdata, mem[bus.cpu_addr]);
    end else begin
      chk("idle_sel", ram_sel, 4'h0);
    end
    wr = eg & bus.cpu_rw; wa = bus.cpu_addr; ws = bus.cpu_sel; wd = bus.cpu_wdata;
    if (!scan_en) begin
      m_on = 0; exp_dv = 0;
    end else if (!m_on) begin
      m_on = 1; m_pend = 1; m_k = 0; m_den = 0;
    end else if (m_pend) begin
      if (sr) begin
        exp_dd = mem[sa]; exp_da = sa; exp_dv = 1;
        m_pend = 0; m_hold = HOLD; m_den = 0;
      end else m_den++;
    end else begin
      m_hold--;
      if (m_hold == 0) begin m_pend = 1; m_k++; end
    end
    @(posedge clk);
    if (wr) for (int b = 0; b < 4; b++) if (ws[b]) mem[wa][8*b +: 8] = wd[8*b +: 8];
    #1;
    chk("disp_valid", disp_valid, exp_dv);
    chk("disp_addr", disp_addr, exp_da);
    chk("disp_data", disp_data, exp_dd);
    @(negedge clk);
  endtask

  task automatic cpu_idle();
    bus.cpu_req = 0; bus.cpu_rw = 0; bus.cpu_sel = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
  endtask

  task automatic cpu_rand(input int pct);
    bus.cpu_req   = ($urandom_range(99) < pct);
    bus.cpu_rw    = $urandom_range(1);
    bus.cpu_sel   = 4'($urandom);
    bus.cpu_addr  = AW'($urandom_range(15));
    bus.cpu_wdata = $urandom;
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[8] = 32'hAAAA_0008; mem[9] = 32'hBBBB_0009; mem[10] = 32'hCCCC_000A;
    cpu_idle();
    scan_en = 0; scan_base = '0; scan_len = '0;
    rst = 0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_valid", disp_valid, 1'b0);
    chk("rst_addr", disp_addr, '0);
    chk("rst_data", disp_data, '0);
    chk("rst_ram_rw", ram_rw, 1'b0);
    @(negedge clk);
    rst = 1;

    // Uncontended scan of 8..10.
    scan_base = 10'd8; scan_len = 10'd3; scan_en = 1;
    for (int i = 0; i < 24; i++) cyc();

    // CPU hammering: starvation forcing.
    bus.cpu_req = 1; bus.cpu_rw = 0; bus.cpu_sel = 4'hf; bus.cpu_addr = 10'd3;
    for (int i = 0; i < 30; i++) cyc();
    cpu_idle();

    // CPU write to 9 while scan is pending; scan must later show it.
    for (int i = 0; i < 40 && !(m_on && m_pend && m_den == 0); i++) cyc();
    bus.cpu_req = 1; bus.cpu_rw = 1; bus.cpu_sel = 4'hf;
    bus.cpu_addr = 10'd9; bus.cpu_wdata = 32'hDEAD_BEEF;
    cyc();
    cpu_idle();
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (disp_valid && disp_addr == 10'd9) seen = 1;
    end
    chk("addr9_seen", seen, 1'b1);
    chk("addr9_data", disp_data, 32'hDEAD_BEEF);

    // Drop scan_en (wherever it lands) with CPU traffic.
    for (int i = 0; i < 3; i++) cyc();
    scan_en = 0;
    for (int i = 0; i < 8; i++) begin cpu_rand(70); cyc(); end
    cpu_idle();

    // Window across the top of the address space.
    scan_base = 10'd1022; scan_len = 10'd4; scan_en = 1;
    for (int i = 0; i < 30; i++) cyc();
    scan_en = 0; cyc();
    scan_len = 10'd0; scan_base = 10'd5; scan_en = 1;
    for (int i = 0; i < 14; i++) cyc();

    // Asynchronous reset in the middle of a dwell.
    for (int i = 0; i < 20 && !(exp_dv && !m_pend && m_hold == 2); i++) cyc();
    chk("dwell_reached", exp_dv && !m_pend, 1'b1);
    #2 rst = 0;
    #1;
    chk("arst_valid", disp_valid, 1'b0);
    chk("arst_addr", disp_addr, '0);
    chk("arst_data", disp_data, '0);
    chk("arst_ram_rw", ram_rw, 1'b0);
    chk("arst_ram_sel", ram_sel, 4'h0);
    model_reset();
    @(negedge clk);
    rst = 1;

    // Random traffic; window only reprogrammed while scanning is off.
    for (int i = 0; i < 1500; i++) begin
      cpu_rand(60);
      if (scan_en && $urandom_range(99) < 2) scan_en = 0;
      else if (!scan_en && $urandom_range(99) < 30) begin
        scan_base = ($urandom_range(3) == 0) ? AW'(1020 + $urandom_range(3)) : AW'($urandom_range(12));
        scan_len  = AW'($urandom_range(6));
        scan_en   = 1;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
